fp32_divider: RTL and testbench

Sequential IEEE-754 single-precision divider, quotient_o = a_i / b_i. It is the inverse-operation companion to the team's 32-bit FP multiplier and uses the same start/done handshake and the same flag set, plus a divide-by-zero flag. The core is a radix-2 restoring mantissa divider that produces one quotient bit per clock. Rounding is round-to-nearest-even. Subnormals are flushed to zero on input and on output.

---
 rtl/fp32_divider.sv | 188 ++++++++++++++++++
 tb/tb_fp32_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider (a / b), one quotient bit per clock,
// round-to-nearest-even, subnormals flushed to zero on input and output.
module fp32_divider #(
    parameter int unsigned QBITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quotient_o,
    output logic        done_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        div_by_zero_o
);

    localparam int unsigned CW = $clog2(QBITS);
    localparam int unsigned MW = 24;
    localparam int unsigned RW = MW + 2;
    localparam int unsigned EW = 10;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_ROUND, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic                 r_sign;
    logic signed [EW-1:0] r_exp;
    logic [MW-1:0]        r_mb;
    logic [RW-1:0]        r_rem;
    logic [QBITS-1:0]     r_q;
    logic [CW-1:0]        r_cnt;

    // Operand decode of the captured operands
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
    logic [MW-1:0] w_ma, w_mb;

    assign w_ea      = r_a[30:23];
    assign w_eb      = r_b[30:23];
    assign w_fa      = r_a[22:0];
    assign w_fb      = r_b[22:0];
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_b_zero  = (w_eb == 8'd0);
    assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;
    assign w_ma      = {1'b1, w_fa};
    assign w_mb      = {1'b1, w_fb};

    // Restoring divide step
    logic           w_rem_ge;
    logic [RW-1:0]  w_rem_sub;

    assign w_rem_ge  = (r_rem >= RW'(r_mb));
    assign w_rem_sub = w_rem_ge ? (r_rem - RW'(r_mb)) : r_rem;

    // Rounding of q[24:1] with guard q[0] and sticky from the remainder
    logic [MW-1:0]        w_sig;
    logic                 w_round_up;
    logic [MW:0]          w_sig_rnd;
    logic                 w_carry;
    logic signed [EW-1:0] w_exp_rnd;
    logic [22:0]          w_frac;

    assign w_sig      = r_q[QBITS-1:1];
    assign w_round_up = r_q[0] & ((r_rem != RW'(0)) | w_sig[0]);
    assign w_sig_rnd  = {1'b0, w_sig} + (MW+1)'(w_round_up);
    assign w_carry    = w_sig_rnd[MW];
    assign w_exp_rnd  = r_exp + EW'(w_carry);
    assign w_frac     = w_carry ? w_sig_rnd[23:1] : w_sig_rnd[22:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = start_i ? S_PREP : S_IDLE;
            S_PREP:         w_state_nxt = w_special ? S_DONE : S_DIV;
            S_DIV:          if (r_cnt == CW'(QBITS - 1)) w_state_nxt = S_ROUND;
            S_ROUND:        w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a           <= '0;
            r_b           <= '0;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_mb          <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_cnt         <= '0;
            quotient_o    <= '0;
            done_o        <= 1'b0;
            nan_o         <= 1'b0;
            infinit_o     <= 1'b0;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_a <= a_i;
                        r_b <= b_i;
                    end
                end
                S_PREP: begin
                    r_sign <= r_a[31] ^ r_b[31];
                    r_mb   <= w_mb;
                    r_q    <= '0;
                    r_cnt  <= '0;
                    // Pre-normalise so the quotient lands in [1,2)
                    if (w_ma < w_mb) begin
                        r_rem <= {1'b0, w_ma, 1'b0};
                        r_exp <= EW'(w_ea) - EW'(w_eb) + EW'(126);
                    end else begin
                        r_rem <= {2'b00, w_ma};
                        r_exp <= EW'(w_ea) - EW'(w_eb) + EW'(127);
                    end
                    if (w_special) begin
                        done_o        <= 1'b1;
                        overflow_o    <= 1'b0;
                        underflow_o   <= 1'b0;
                        nan_o         <= 1'b0;
                        infinit_o     <= 1'b0;
                        div_by_zero_o <= 1'b0;
                        if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
                            quotient_o <= 32'h7FC0_0000;
                            nan_o      <= 1'b1;
                        end else if (w_a_inf) begin
                            quotient_o <= {r_a[31] ^ r_b[31], 31'h7F80_0000};
                            infinit_o  <= 1'b1;
                        end else if (w_b_zero) begin
                            quotient_o    <= {r_a[31] ^ r_b[31], 31'h7F80_0000};
                            infinit_o     <= 1'b1;
                            div_by_zero_o <= 1'b1;
                        end else begin
                            quotient_o <= {r_a[31] ^ r_b[31], 31'h0};
                        end
                    end
                end
                S_DIV: begin
                    r_q   <= {r_q[QBITS-2:0], w_rem_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_ROUND: begin
                    done_o        <= 1'b1;
                    nan_o         <= 1'b0;
                    div_by_zero_o <= 1'b0;
                    if (w_exp_rnd >= EW'(255)) begin
                        quotient_o  <= {r_sign, 31'h7F80_0000};
                        overflow_o  <= 1'b1;
                        infinit_o   <= 1'b1;
                        underflow_o <= 1'b0;
                    end else if (w_exp_rnd <= EW'(0)) begin
                        quotient_o  <= {r_sign, 31'h0};
                        overflow_o  <= 1'b0;
                        infinit_o   <= 1'b0;
                        underflow_o <= 1'b1;
                    end else begin
                        quotient_o  <= {r_sign, w_exp_rnd[7:0], w_frac};
                        overflow_o  <= 1'b0;
                        infinit_o   <= 1'b0;
                        underflow_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed self-checking bench for fp32_divider: results, flags, latency,
// back-to-back throughput and mid-operation reset.
module tb_fp32_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] a_i, b_i;
    logic [31:0] quotient_o;
    logic        done_o, nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fp32_divider dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .quotient_o   (quotient_o),
        .done_o       (done_o),
        .nan_o        (nan_o),
        .infinit_o    (infinit_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // flags packed as {nan, inf, ovf, unf, dbz}
    function automatic logic [4:0] flags();
        return {nan_o, infinit_o, overflow_o, underflow_o, div_by_zero_o};
    endfunction

    // Wait (bounded) for done_o, sampled 1ns after each rising edge
    task automatic wait_done(output int at_cyc, output bit timeout);
        timeout = 1'b1;
        at_cyc  = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                at_cyc  = cyc;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    // Launch one operation and return result, flags and latency in cycles
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [4:0] f,
                          output int lat, output bit timeout);
        int c0, c1;
        @(negedge clk);
        a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start_i = 1'b0;
        a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678;
        wait_done(c1, timeout);
        lat = c1 - c0;
        q   = quotient_o;
        f   = flags();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
        #12;
        checks++;
        if (quotient_o !== 32'h0) begin errors++; $display("FAIL reset_quotient got=%h exp=00000000", quotient_o); end
        checks++;
        if (flags() !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", flags()); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] q; logic [4:0] f; int lat; bit to;
        run_op(32'h40C0_0000, 32'h4000_0000, q, f, lat, to);
        checks++;
        if (to || q !== 32'h4040_0000 || f !== 5'b0) begin
            errors++; $display("FAIL basic_6div2 got=%h flags=%b to=%0d exp=40400000 flags=00000", q, f, to);
        end
        checks++;
        if (lat !== 27) begin errors++; $display("FAIL basic_latency got=%0d exp=27", lat); end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done_o); end
    endtask

    task automatic test_rounding();
        logic [31:0] va [2] = '{32'h3F80_0000, 32'h3F80_0000};
        logic [31:0] vb [2] = '{32'h4040_0000, 32'h3F80_0001};
        logic [31:0] vq [2] = '{32'h3EAA_AAAB, 32'h3F7F_FFFE};
        logic [31:0] q; logic [4:0] f; int lat; bit to;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], q, f, lat, to);
            checks++;
            if (to || q !== vq[i] || f !== 5'b0) begin
                errors++; $display("FAIL rounding_%0d got=%h flags=%b exp=%h flags=00000", i, q, f, vq[i]);
            end
        end
    endtask

    task automatic test_ovf_unf();
        logic [31:0] q; logic [4:0] f; int lat; bit to;
        run_op(32'h7F00_0000, 32'h0080_0000, q, f, lat, to);
        checks++;
        if (to || q !== 32'h7F80_0000 || f !== 5'b01100) begin
            errors++; $display("FAIL overflow got=%h flags=%b exp=7f800000 flags=01100", q, f);
        end
        run_op(32'h0080_0000, 32'h7F00_0000, q, f, lat, to);
        checks++;
        if (to || q !== 32'h0000_0000 || f !== 5'b00010) begin
            errors++; $display("FAIL underflow got=%h flags=%b exp=00000000 flags=00010", q, f);
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [4] = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h4000_0000};
        logic [31:0] vb [4] = '{32'h8000_0000, 32'h0000_0000, 32'h7F80_0000, 32'hFF80_0000};
        logic [31:0] vq [4] = '{32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000};
        logic [4:0]  vf [4] = '{5'b01001, 5'b10000, 5'b10000, 5'b00000};
        logic [31:0] q; logic [4:0] f; int lat; bit to;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], q, f, lat, to);
            checks++;
            if (to || q !== vq[i] || f !== vf[i]) begin
                errors++; $display("FAIL special_%0d got=%h flags=%b exp=%h flags=%b", i, q, f, vq[i], vf[i]);
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL special_latency_%0d got=%0d exp=1", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3] = '{32'h40C0_0000, 32'h3F80_0000, 32'h7F00_0000};
        logic [31:0] vb [3] = '{32'h4000_0000, 32'h4040_0000, 32'h0080_0000};
        logic [31:0] vq [3] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'h7F80_0000};
        int t [3];
        bit to;
        @(negedge clk);
        a_i = va[0]; b_i = vb[0]; start_i = 1'b1;
        @(posedge clk);
        #1;
        a_i = 32'h4100_0000; b_i = 32'h3F80_0000;
        for (int i = 0; i < 3; i++) begin
            wait_done(t[i], to);
            checks++;
            if (to || quotient_o !== vq[i]) begin
                errors++; $display("FAIL b2b_result_%0d got=%h to=%0d exp=%h", i, quotient_o, to, vq[i]);
            end
            if (i < 2) begin
                a_i = va[i+1]; b_i = vb[i+1];
                @(posedge clk);
                #1;
                a_i = 32'h4100_0000; b_i = 32'h3F80_0000;
            end else begin
                start_i = 1'b0;
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (t[i] - t[i-1] !== 28) begin
                errors++; $display("FAIL b2b_period_%0d got=%0d exp=28", i, t[i] - t[i-1]);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] q; logic [4:0] f; int lat; bit to;
        bit seen;
        @(negedge clk);
        a_i = 32'h40C0_0000; b_i = 32'h4000_0000; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (quotient_o !== 32'h0 || flags() !== 5'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got=%h flags=%b done=%b exp=00000000 flags=00000 done=0",
                               quotient_o, flags(), done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midreset_no_done got=1 exp=0"); end
        run_op(32'h40C0_0000, 32'h4000_0000, q, f, lat, to);
        checks++;
        if (to || q !== 32'h4040_0000 || f !== 5'b0 || lat !== 27) begin
            errors++; $display("FAIL midreset_recover got=%h flags=%b lat=%0d exp=40400000 flags=00000 lat=27", q, f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_ovf_unf();
        test_specials();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
